imem_responder: RTL and testbench

Instruction-memory responder that serves the fetch stage's `o_Imem_stb`/`o_Iaddr` requests with a word-addressed instruction array. It returns `o_Inst` together with a one-cycle `o_Imem_ack`. Its latency is fixed at one cycle by default and can optionally be stretched by a wait-state counter. It sits between the IF stage and the instruction store, and it is the bench model and FPGA block-RAM wrapper for fetch.

---
 rtl/imem_responder.sv | 151 +++++++++++++++
 tb/tb_imem_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
`default_nettype none
// =============================================================================
// Module   : imem_responder
// Word-addressed instruction store answering IF-stage fetches with a one-cycle
// registered ack; wait states are compiled in with `define IMEM_WAITSTATE_EN.
// Revision : 1.0
// =============================================================================
module imem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] RESET_INST  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_Imem_stb,
    input  logic [31:0] i_Iaddr,
    output logic [31:0] o_Inst,
    output logic        o_Imem_ack,
    output logic        o_Imem_err,
    input  logic        i_Wr_en,
    input  logic [31:0] i_Wr_addr,
    input  logic [31:0] i_Wr_data
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

`ifdef IMEM_WAITSTATE_EN
    localparam bit HAS_WAIT = (WAIT_CYCLES > 0);
    localparam int WCW      = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    logic [WCW-1:0] wcnt_q, wcnt_d;
`else
    // Without wait states the configured count has no effect.
    localparam bit HAS_WAIT = (WAIT_CYCLES > 0) && 1'b0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd2
    } state_t;
`endif

    logic [31:0] mem [DEPTH_WORDS];

    state_t      state_q, state_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] inst_q,  inst_d;
    logic        ack_q,   ack_d;
    logic        err_q,   err_d;

    logic [31:0] w_roff, w_ridx, w_woff, w_widx_full;
    logic        w_rerr, w_wr_ok;
    logic [31:0] w_rdata;

    // Range check on the full 32-bit word index so wrap-around cannot alias.
    assign w_roff      = addr_q - BASE_ADDR;
    assign w_ridx      = w_roff >> 2;
    assign w_rerr      = (addr_q[1:0] != 2'b00) || (addr_q < BASE_ADDR) ||
                         (w_ridx >= 32'(DEPTH_WORDS));
    assign w_rdata     = w_rerr ? RESET_INST : mem[w_ridx[AW-1:0]];

    assign w_woff      = i_Wr_addr - BASE_ADDR;
    assign w_widx_full = w_woff >> 2;
    assign w_wr_ok     = i_Wr_en && (i_Wr_addr[1:0] == 2'b00) &&
                         (i_Wr_addr >= BASE_ADDR) && (w_widx_full < 32'(DEPTH_WORDS));

    // Array is deliberately outside reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            mem[w_widx_full[AW-1:0]] <= i_Wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= 32'h0;
            inst_q  <= RESET_INST;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef IMEM_WAITSTATE_EN
            wcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
`ifdef IMEM_WAITSTATE_EN
            wcnt_q  <= wcnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        inst_d  = inst_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
`ifdef IMEM_WAITSTATE_EN
        wcnt_d  = wcnt_q;
`endif
        // The response registers load on the ACK-state edge, so a write on that
        // same edge is seen only by later fetches (read-before-write).
        if (state_q == S_ACK) begin
            ack_d  = 1'b1;
            inst_d = w_rdata;
            err_d  = w_rerr;
            state_d = S_IDLE;
        end

        case (state_q)
            S_IDLE, S_ACK: begin
                if (i_Imem_stb) begin
                    addr_d = i_Iaddr;
                    if (HAS_WAIT) begin
`ifdef IMEM_WAITSTATE_EN
                        wcnt_d  = WCW'(WAIT_CYCLES);
                        state_d = S_WAIT;
`endif
                    end else begin
                        state_d = S_ACK;
                    end
                end
            end
`ifdef IMEM_WAITSTATE_EN
            S_WAIT: begin
                wcnt_d = wcnt_q - WCW'(1);
                if (wcnt_q <= WCW'(1)) begin
                    state_d = S_ACK;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign o_Inst     = inst_q;
    assign o_Imem_ack = ack_q;
    assign o_Imem_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// =============================================================================
// Module   : tb_imem_responder
// Scoreboard bench for imem_responder: stimulus pushes expected responses,
// a negedge monitor pops and compares on every ack.
// Revision : 1.0
// =============================================================================
module tb_imem_responder;

    localparam int          DEPTH = 1024;
    localparam int          WAITC = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef IMEM_WAITSTATE_EN
    localparam int LAT = 1 + WAITC;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stb;
    logic [31:0] iaddr;
    logic [31:0] inst;
    logic        ack;
    logic        err;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    imem_responder #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (32'h0000_0000),
        .WAIT_CYCLES (WAITC),
        .RESET_INST  (NOP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_Imem_stb (stb),
        .i_Iaddr    (iaddr),
        .o_Inst     (inst),
        .o_Imem_ack (ack),
        .o_Imem_err (err),
        .i_Wr_en    (wr_en),
        .i_Wr_addr  (wr_addr),
        .i_Wr_data  (wr_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic        err;
        int          cyc;
        int          tag;
    } exp_t;

    exp_t        q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          ack_cnt  = 0;
    logic [31:0] last_inst;
    bit          hold_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int tag, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %h expected %h", name, tag, act, exp);
        end
    endtask

    // Monitor: compare every ack against the scoreboard; check hold otherwise.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_valid = 1'b0;
        end else if (ack === 1'b1) begin
            ack_cnt++;
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("inst", e.tag, inst, e.inst);
                check("err", e.tag, {31'b0, err}, {31'b0, e.err});
                check("ack_cycle", e.tag, cyc, e.cyc);
            end
            last_inst  = inst;
            hold_valid = 1'b1;
        end else if (hold_valid) begin
            check("hold_inst", cyc, inst, last_inst);
            check("idle_err", cyc, {31'b0, err}, 32'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic push(input logic [31:0] i, input logic e, input int c, input int tag);
        exp_t x;
        x.inst = i; x.err = e; x.cyc = c; x.tag = tag;
        q.push_back(x);
    endtask

    // Drive one request; it is accepted at the next edge.
    task automatic fetch(input logic [31:0] a, input logic [31:0] i, input logic e,
                         input int tag);
        stb = 1'b1; iaddr = a;
        push(i, e, cyc + 1 + LAT, tag);
        tick();
        stb = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && q.size() > 0; n++) tick();
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d responses pending expected 0", q.size());
            q.delete();
        end
        repeat (2) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        rst_n = 1'b0; stb = 1'b0; iaddr = 32'h0;
        wr_en = 1'b0; wr_addr = 32'h0; wr_data = 32'h0;
        tick(); tick();
        @(negedge clk);
        check("rst_ack", 0, {31'b0, ack}, 32'h0);
        check("rst_err", 0, {31'b0, err}, 32'h0);
        check("rst_inst", 0, inst, NOP);
        rst_n = 1'b1;
        tick();

        wr(32'h0, 32'h0010_6293);
        wr(32'h4, 32'h0000_00EF);
        wr(32'h8, 32'h00A0_0513);
        wr(32'hC, 32'hFEDC_BA98);
        wr(32'h10, 32'h1111_1111);
        wr(32'hFFC, 32'h55AA_55AA);
        // Out-of-range and misaligned writes must be dropped.
        wr(32'h1000, 32'hBAD0_BAD0);
        wr(32'h6, 32'hBAD1_BAD1);

        fetch(32'h0, 32'h0010_6293, 1'b0, 1); drain();
        fetch(32'h4, 32'h0000_00EF, 1'b0, 2); drain();

`ifdef IMEM_WAITSTATE_EN
        // Held strobe: one ack every LAT cycles.
        stb = 1'b1; iaddr = 32'h4;
        push(32'h0000_00EF, 1'b0, cyc + 1 + LAT, 3);
        push(32'h0000_00EF, 1'b0, cyc + 1 + 2 * LAT, 4);
        repeat (LAT + 1) tick();
        stb = 1'b0;
        drain();
`else
        // Streaming: new address every cycle, ack high continuously.
        stb = 1'b1;
        iaddr = 32'h0; push(32'h0010_6293, 1'b0, cyc + 1 + LAT, 3); tick();
        iaddr = 32'h4; push(32'h0000_00EF, 1'b0, cyc + 1 + LAT, 4); tick();
        iaddr = 32'h8; push(32'h00A0_0513, 1'b0, cyc + 1 + LAT, 5); tick();
        stb = 1'b0;
        drain();
`endif

        // Address changes after acceptance must not alter the response.
        fetch(32'hC, 32'hFEDC_BA98, 1'b0, 6);
        iaddr = 32'h0;
        tick();
        iaddr = 32'h8;
        drain();

        fetch(32'h2, NOP, 1'b1, 7); drain();
        fetch(32'h1000, NOP, 1'b1, 8); drain();
        fetch(32'hFFC, 32'h55AA_55AA, 1'b0, 9); drain();
        fetch(32'h4, 32'h0000_00EF, 1'b0, 10); drain();
        fetch(32'h1000_0000, NOP, 1'b1, 11); drain();

        // Collision: write lands on the ack-producing edge.
        fetch(32'h10, 32'h1111_1111, 1'b0, 12);
        repeat (LAT - 1) tick();
        wr(32'h10, 32'hDEAD_BEEF);
        drain();
        fetch(32'h10, 32'hDEAD_BEEF, 1'b0, 13); drain();

        // Reset with a request in flight: dropped, then immediate re-accept.
        a0 = ack_cnt;
        stb = 1'b1; iaddr = 32'h0;
        tick();
        stb = 1'b0; rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        fetch(32'h8, 32'h00A0_0513, 1'b0, 14);
        drain();
        check("rst_drop_acks", 15, ack_cnt - a0, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
